// File: rtl/seeed_tft_sequencer.sv
// Front-end sequencer for seeed_tft_command: arbitrates host register
// accesses against pixel bursts and drives the engine's strobe/data/RS.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_host_*/o_host_*             single-byte host read/write access
//   i_pix_*/o_pix_*               burst start, pixel stream handshake, status
//   o_cmd_*/o_enable              strobes, byte and RS to the command engine
//   i_cmd_data, i_cmd_finished    read result and completion from the engine
module seeed_tft_sequencer #(
    parameter logic [7:0] MEM_WRITE_CMD = 8'h2C,
    parameter int         COUNT_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_host_req,
    input  logic                   i_host_rw,
    input  logic                   i_host_rs,
    input  logic [7:0]             i_host_data,
    output logic                   o_host_ack,
    output logic [7:0]             o_host_data,
    input  logic                   i_pix_start,
    input  logic [COUNT_WIDTH-1:0] i_pix_count,
    input  logic [15:0]            i_pix_data,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    output logic                   o_pix_busy,
    output logic                   o_pix_done,
    output logic                   o_cmd_write_stb,
    output logic                   o_cmd_read_stb,
    output logic [7:0]             o_cmd_data,
    output logic                   o_cmd_rs,
    output logic                   o_enable,
    input  logic [7:0]             i_cmd_data,
    input  logic                   i_cmd_finished
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_HOST_ISSUE = 4'd1;
    localparam logic [3:0] S_HOST_WAIT  = 4'd2;
    localparam logic [3:0] S_CMD_ISSUE  = 4'd3;
    localparam logic [3:0] S_CMD_WAIT   = 4'd4;
    localparam logic [3:0] S_FETCH      = 4'd5;
    localparam logic [3:0] S_HI_ISSUE   = 4'd6;
    localparam logic [3:0] S_HI_WAIT    = 4'd7;
    localparam logic [3:0] S_LO_ISSUE   = 4'd8;
    localparam logic [3:0] S_LO_WAIT    = 4'd9;
    localparam logic [3:0] S_DONE       = 4'd10;

    logic [3:0]             state_q, state_d;
    logic [7:0]             cmd_data_q, cmd_data_d;
    logic                   cmd_rs_q, cmd_rs_d;
    logic                   rw_q, rw_d;
    logic                   ack_q, ack_d;
    logic [7:0]             host_data_q, host_data_d;
    logic                   pend_q, pend_d;
    logic [COUNT_WIDTH-1:0] pend_cnt_q, pend_cnt_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]             pix_lo_q, pix_lo_d;

    always_comb begin
        state_d     = state_q;
        cmd_data_d  = cmd_data_q;
        cmd_rs_d    = cmd_rs_q;
        rw_d        = rw_q;
        ack_d       = 1'b0;
        host_data_d = host_data_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        cnt_d       = cnt_q;
        pix_lo_d    = pix_lo_q;

        // Any start is remembered; IDLE clears it again if it takes the burst.
        if (i_pix_start) begin
            pend_d     = 1'b1;
            pend_cnt_d = i_pix_count;
        end

        case (state_q)
            S_IDLE: begin
                if (i_host_req) begin
                    state_d    = S_HOST_ISSUE;
                    rw_d       = i_host_rw;
                    cmd_rs_d   = i_host_rs;
                    cmd_data_d = i_host_data;
                end else if (i_pix_start || pend_q) begin
                    state_d    = S_CMD_ISSUE;
                    cnt_d      = i_pix_start ? i_pix_count : pend_cnt_q;
                    pend_d     = 1'b0;
                    rw_d       = 1'b0;
                    cmd_rs_d   = 1'b0;
                    cmd_data_d = MEM_WRITE_CMD;
                end
            end
            S_HOST_ISSUE: state_d = S_HOST_WAIT;
            S_HOST_WAIT: begin
                if (i_cmd_finished) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    if (rw_q) host_data_d = i_cmd_data;
                end
            end
            S_CMD_ISSUE: state_d = S_CMD_WAIT;
            S_CMD_WAIT: begin
                if (i_cmd_finished)
                    state_d = (cnt_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (i_pix_valid) begin
                    state_d    = S_HI_ISSUE;
                    pix_lo_d   = i_pix_data[7:0];
                    cmd_data_d = i_pix_data[15:8];
                    cmd_rs_d   = 1'b1;
                end
            end
            S_HI_ISSUE: state_d = S_HI_WAIT;
            S_HI_WAIT: begin
                if (i_cmd_finished) begin
                    state_d    = S_LO_ISSUE;
                    cmd_data_d = pix_lo_q;
                end
            end
            S_LO_ISSUE: state_d = S_LO_WAIT;
            S_LO_WAIT: begin
                if (i_cmd_finished) begin
                    cnt_d   = cnt_q - COUNT_WIDTH'(1);
                    // count is never zero here, so 1 means this was the last pixel
                    state_d = (cnt_q == COUNT_WIDTH'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_data_q  <= '0;
            cmd_rs_q    <= 1'b0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            host_data_q <= '0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
            cnt_q       <= '0;
            pix_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_data_q  <= cmd_data_d;
            cmd_rs_q    <= cmd_rs_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            host_data_q <= host_data_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            cnt_q       <= cnt_d;
            pix_lo_q    <= pix_lo_d;
        end
    end

    // Strobes are decoded from the registered state, so each is a clean
    // one-cycle pulse during the matching ISSUE state.
    assign o_cmd_write_stb = (state_q == S_HOST_ISSUE && !rw_q)
                           || state_q == S_CMD_ISSUE
                           || state_q == S_HI_ISSUE
                           || state_q == S_LO_ISSUE;
    assign o_cmd_read_stb  = (state_q == S_HOST_ISSUE) && rw_q;
    assign o_cmd_data      = cmd_data_q;
    assign o_cmd_rs        = cmd_rs_q;
    assign o_enable        = (state_q != S_IDLE);
    assign o_host_ack      = ack_q;
    assign o_host_data     = host_data_q;
    assign o_pix_ready     = (state_q == S_FETCH);
    assign o_pix_busy      = (state_q >= S_CMD_ISSUE) && (state_q <= S_LO_WAIT);
    assign o_pix_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seeed_tft_sequencer.sv
// Directed bench for seeed_tft_sequencer with a simple command-engine model
// that answers each strobe with a finished pulse a few cycles later.
module tb_seeed_tft_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_host_req, i_host_rw, i_host_rs;
    logic [7:0]  i_host_data;
    logic        o_host_ack;
    logic [7:0]  o_host_data;
    logic        i_pix_start;
    logic [23:0] i_pix_count;
    logic [15:0] i_pix_data;
    logic        i_pix_valid;
    logic        o_pix_ready, o_pix_busy, o_pix_done;
    logic        o_cmd_write_stb, o_cmd_read_stb;
    logic [7:0]  o_cmd_data;
    logic        o_cmd_rs, o_enable;
    logic [7:0]  i_cmd_data;
    logic        i_cmd_finished = 1'b0;

    seeed_tft_sequencer dut (
        .clk(clk), .rst(rst),
        .i_host_req(i_host_req), .i_host_rw(i_host_rw),
        .i_host_rs(i_host_rs), .i_host_data(i_host_data),
        .o_host_ack(o_host_ack), .o_host_data(o_host_data),
        .i_pix_start(i_pix_start), .i_pix_count(i_pix_count),
        .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready), .o_pix_busy(o_pix_busy),
        .o_pix_done(o_pix_done),
        .o_cmd_write_stb(o_cmd_write_stb), .o_cmd_read_stb(o_cmd_read_stb),
        .o_cmd_data(o_cmd_data), .o_cmd_rs(o_cmd_rs), .o_enable(o_enable),
        .i_cmd_data(i_cmd_data), .i_cmd_finished(i_cmd_finished)
    );

    always #5 clk = ~clk;

    wire [23:0] outs = {o_host_ack, o_host_data, o_pix_ready, o_pix_busy,
                        o_pix_done, o_cmd_write_stb, o_cmd_read_stb,
                        o_cmd_data, o_cmd_rs, o_enable};

    // engine model and monitors; log entry = {read, rs, byte}
    logic [9:0] log_q[$];
    int busy_cnt = 0, overlap = 0, cyc = 0, fin_cyc = 0, ack_gap = -1;
    int ack_cnt = 0, done_cnt = 0, ready_cnt = 0, done_busy = 0;

    always @(posedge clk) begin
        i_cmd_finished <= 1'b0;
        cyc <= cyc + 1;
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) i_cmd_finished <= 1'b1;
        end
        if (o_cmd_write_stb || o_cmd_read_stb) begin
            if (busy_cnt > 0 || (o_cmd_write_stb && o_cmd_read_stb))
                overlap <= overlap + 1;
            busy_cnt <= 2;
            log_q.push_back({o_cmd_read_stb, o_cmd_rs, o_cmd_data});
        end
        if (i_cmd_finished) fin_cyc <= cyc;
        if (o_host_ack) begin
            ack_cnt <= ack_cnt + 1;
            ack_gap <= cyc - fin_cyc;
        end
        if (o_pix_done) done_cnt <= done_cnt + 1;
        if (o_pix_done && o_pix_busy) done_busy <= done_busy + 1;
        if (o_pix_ready) ready_cnt <= ready_cnt + 1;
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        int b = ack_cnt;
        for (int n = 0; n < 60 && ack_cnt == b; n++) tick();
        check(tag, 32'(ack_cnt != b), 1);
    endtask

    task automatic wait_done(input string tag);
        int b = done_cnt;
        for (int n = 0; n < 80 && done_cnt == b; n++) tick();
        check(tag, 32'(done_cnt != b), 1);
    endtask

    task automatic send_pixel(input logic [15:0] d, input string tag);
        logic ok = 1'b0;
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        for (int n = 0; n < 60; n++) begin
            if (o_pix_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        i_pix_valid = 1'b0;
        check(tag, 32'(ok), 1);
    endtask

    task automatic host(input logic rw, input logic rs, input logic [7:0] d);
        i_host_req  = 1'b1;
        i_host_rw   = rw;
        i_host_rs   = rs;
        i_host_data = d;
        tick();
        i_host_req  = 1'b0;
    endtask

    task automatic start(input logic [23:0] c);
        i_pix_start = 1'b1;
        i_pix_count = c;
        tick();
        i_pix_start = 1'b0;
    endtask

    int base, ab, db, rb;
    logic [9:0] exp_b[5];
    logic [9:0] exp_a[4];

    initial begin
        rst = 1'b1;
        i_host_req = 0; i_host_rw = 0; i_host_rs = 0; i_host_data = 0;
        i_pix_start = 0; i_pix_count = 0; i_pix_data = 0; i_pix_valid = 0;
        i_cmd_data = 8'h00;
        repeat (3) tick();
        check("reset_outputs", 32'(outs), 0);
        rst = 1'b0;
        tick();

        // host write
        base = log_q.size();
        host(1'b0, 1'b0, 8'h36);
        wait_ack("wr_ack");
        check("wr_nstrobe", 32'(log_q.size() - base), 1);
        check("wr_byte", 32'(log_q[base]), 32'h036);
        check("wr_hostdata", 32'(o_host_data), 0);
        check("wr_ackgap", 32'(ack_gap), 1);

        // host read
        i_cmd_data = 8'hA5;
        base = log_q.size();
        host(1'b1, 1'b1, 8'h00);
        wait_ack("rd_ack");
        check("rd_nstrobe", 32'(log_q.size() - base), 1);
        check("rd_kind", 32'(log_q[base][9:8]), 32'h3);
        check("rd_hostdata", 32'(o_host_data), 32'hA5);
        i_cmd_data = 8'h00;

        // two-pixel burst
        base = log_q.size();
        db = done_cnt;
        start(24'd2);
        check("b2_busy", 32'(o_pix_busy), 1);
        send_pixel(16'hF800, "b2_px0");
        send_pixel(16'h07E0, "b2_px1");
        wait_done("b2_done");
        exp_b = '{10'h02C, 10'h1F8, 10'h100, 10'h107, 10'h1E0};
        check("b2_nbytes", 32'(log_q.size() - base), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("b2_byte%0d", i), 32'(log_q[base+i]), 32'(exp_b[i]));
        tick();
        check("b2_ndone", 32'(done_cnt - db), 1);
        check("b2_busy_after", 32'(o_pix_busy), 0);

        // empty burst
        base = log_q.size();
        db = done_cnt;
        rb = ready_cnt;
        start(24'd0);
        wait_done("b0_done");
        tick();
        check("b0_nbytes", 32'(log_q.size() - base), 1);
        check("b0_byte", 32'(log_q[base]), 32'h02C);
        check("b0_ready", 32'(ready_cnt - rb), 0);
        check("b0_ndone", 32'(done_cnt - db), 1);

        // host and start together, then a dropped host request mid-burst
        base = log_q.size();
        ab = ack_cnt;
        i_pix_start = 1'b1;
        i_pix_count = 24'd1;
        host(1'b0, 1'b1, 8'h11);
        i_pix_start = 1'b0;
        wait_ack("arb_ack");
        tick();
        check("arb_busy", 32'(o_pix_busy), 1);
        host(1'b0, 1'b1, 8'h99);
        send_pixel(16'h1234, "arb_px");
        wait_done("arb_done");
        repeat (6) tick();
        exp_a = '{10'h111, 10'h02C, 10'h112, 10'h134};
        check("arb_nack", 32'(ack_cnt - ab), 1);
        check("arb_nbytes", 32'(log_q.size() - base), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("arb_byte%0d", i), 32'(log_q[base+i]), 32'(exp_a[i]));

        // reset while waiting on the high byte
        base = log_q.size();
        ab = ack_cnt;
        db = done_cnt;
        start(24'd1);
        send_pixel(16'hABCD, "rst_px");
        tick();
        rst = 1'b1;
        tick();
        check("rst_outputs", 32'(outs), 0);
        rst = 1'b0;
        repeat (10) tick();
        check("rst_nbytes", 32'(log_q.size() - base), 2);
        check("rst_hibyte", 32'(log_q[base+1]), 32'h1AB);
        check("rst_ndone", 32'(done_cnt - db), 0);
        check("rst_nack", 32'(ack_cnt - ab), 0);
        check("rst_enable", 32'(o_enable), 0);

        check("strobe_overlap", 32'(overlap), 0);
        check("done_with_busy", 32'(done_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
